score_scan_display: RTL



---
 rtl/score_pkg.sv | 20 ++
 rtl/score_scan_display_seg7_bcd_decode.sv | 29 ++
 rtl/score_scan_display.sv | 119 +++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared constants for the score counter and its seven-segment display path.
package score_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  // Active-low segment codes, bit order gfedcba
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/score_scan_display_seg7_bcd_decode.sv
// Combinational BCD nibble to active-low seven-segment code; out-of-range nibbles go blank.
module seg7_bcd_decode
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] nibble,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_scan_display.sv
// Saturating multi-digit BCD score counter with a time-multiplexed seven-segment driver.
module score_scan_display
  import score_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    clr,
  input  logic                    blank,
  output logic [BCD_W*DIGITS-1:0] score_bcd,
  output logic                    overflow,
  output logic [SEG_W-1:0]        seg,
  output logic [DIGITS-1:0]       an
);

  localparam int unsigned SCORE_W = BCD_W * DIGITS;
  localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]   digit_idx;
  logic [SCORE_W-1:0] score_inc_c;
  logic               all_nines_c;
  logic [DIGITS-1:0]  lz_c;
  logic [BCD_W-1:0]   cur_nib_c;
  logic               cur_lz_c;
  logic [SEG_W-1:0]   dec_seg_c;

  // Ripple decimal carry across all digits, resolved within one cycle
  always_comb begin
    logic             carry;
    logic [BCD_W-1:0] nib;
    score_inc_c = score_bcd;
    all_nines_c = 1'b1;
    carry       = 1'b1;
    nib         = '0;
    for (int k = 0; k < DIGITS; k++) begin
      nib = score_bcd[k*BCD_W +: BCD_W];
      if (nib != BCD_W'(9)) all_nines_c = 1'b0;
      if (carry) begin
        if (nib == BCD_W'(9)) begin
          score_inc_c[k*BCD_W +: BCD_W] = '0;
        end else begin
          score_inc_c[k*BCD_W +: BCD_W] = nib + BCD_W'(1);
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else if (inc) begin
      if (all_nines_c) overflow <= 1'b1;
      else             score_bcd <= score_inc_c;
    end
  end

  // Digit k is a leading zero when it and every higher digit are zero; units never blanks
  always_comb begin
    logic zero_run;
    lz_c     = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run & (score_bcd[k*BCD_W +: BCD_W] == '0);
      lz_c[k]  = (BLANK_LZ != 0) && zero_run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    cur_nib_c = '0;
    cur_lz_c  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_nib_c = score_bcd[k*BCD_W +: BCD_W];
        cur_lz_c  = lz_c[k];
      end
    end
  end

  seg7_bcd_decode u_decode (
    .nibble (cur_nib_c),
    .blank  (cur_lz_c),
    .seg_c  (dec_seg_c)
  );

  // seg and an share one register stage so they always switch together
  always_ff @(posedge clk) begin
    if (rst || blank) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= dec_seg_c;
      an  <= ~(DIGITS'(1) << digit_idx);
    end
  end

endmodule
